tick_timer: RTL and testbench



---
 rtl/tick_timer.sv | 106 ++++++++++
 tb/tb_tick_timer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer.sv
// tick_timer: counts synchronised rising edges of tick_in (free-run / auto-reload / one-shot) and flags overflow.
// Latency: SYNC_STAGES+1 clk_in edges from first high sample of tick_in to count update; no backpressure (levels and strobes only).
module tick_timer #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] reload_val,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] cnt_out,
    output logic             ovf_flag,
    output logic             irq,
    output logic             running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   tick_hist;
    logic                   tick_pulse;
    logic [WIDTH-1:0]       cnt_nxt;
    logic                   ovf_nxt;
    logic                   wrap;

    // tick_in is a data input from another clock domain, never a clock
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_q    <= '0;
            tick_hist <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], tick_in};
            tick_hist <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick_pulse = sync_q[SYNC_STAGES-1] & ~tick_hist;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_out;
        ovf_nxt   = ovf_flag;
        wrap      = 1'b0;

        // load wins over a coincident tick, which is simply dropped
        if (load) begin
            cnt_nxt = load_val;
        end else if (state == RUN && en && tick_pulse && mode != 2'b11) begin
            if (cnt_out != CNT_MAX) begin
                cnt_nxt = cnt_out + 1'b1;
            end else begin
                wrap    = 1'b1;
                cnt_nxt = (mode == 2'b00) ? '0 : reload_val;
            end
        end

        if (wrap) begin
            ovf_nxt = 1'b1;
        end else if (ovf_clr) begin
            ovf_nxt = 1'b0;
        end

        case (state)
            IDLE: if (en) state_nxt = RUN;
            RUN: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (wrap && mode == 2'b10) begin
                    state_nxt = DONE;
                end
            end
            DONE: if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state    <= IDLE;
            cnt_out  <= '0;
            ovf_flag <= 1'b0;
            irq      <= 1'b0;
            running  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt_out  <= cnt_nxt;
            ovf_flag <= ovf_nxt;
            irq      <= wrap;
            running  <= (state_nxt == RUN);
        end
    end

endmodule

// File: tb/tb_tick_timer.sv
// Bench for tick_timer: a 4-bit and a 16-bit instance share stimulus; directed steps then random traffic,
// every cycle checked against a rule-level reference model.
module tb_tick_timer;

    localparam int S = 2;

    logic        clk_in = 1'b0;
    logic        rst, tick_in, en, load, ovf_clr;
    logic [1:0]  mode;
    logic [15:0] reload_val, load_val;
    logic [3:0]  cnt4;
    logic        ovf4, irq4, run4;
    logic [15:0] cnt16;
    logic        ovf16, irq16, run16;

    always #5 clk_in = ~clk_in;

    tick_timer #(.WIDTH(4), .SYNC_STAGES(S)) u4 (
        .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .en(en), .mode(mode),
        .reload_val(reload_val[3:0]), .load(load), .load_val(load_val[3:0]),
        .ovf_clr(ovf_clr), .cnt_out(cnt4), .ovf_flag(ovf4), .irq(irq4), .running(run4)
    );

    tick_timer #(.WIDTH(16), .SYNC_STAGES(S)) u16 (
        .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .en(en), .mode(mode),
        .reload_val(reload_val), .load(load), .load_val(load_val),
        .ovf_clr(ovf_clr), .cnt_out(cnt16), .ovf_flag(ovf16), .irq(irq16), .running(run16)
    );

    // Reference model: index 0 = 4-bit instance, 1 = 16-bit instance. State 0 idle, 1 run, 2 done.
    int unsigned m_cnt[2];
    bit          m_ovf[2];
    bit          m_irq[2];
    int          m_st[2];
    int unsigned m_max[2] = '{15, 65535};
    bit          h[0:S];   // h[0] newest tick_in sample

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0; m_ovf[d] = 0; m_irq[d] = 0; m_st[d] = 0;
        end
        for (int i = 0; i <= S; i++) h[i] = 1'b0;
    end

    always @(posedge clk_in) begin
        bit pulse;
        bit wrap;
        // a rising edge of tick_in becomes usable S samples after it is first seen
        pulse = h[S-1] & ~h[S];
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_cnt[d] = 0; m_ovf[d] = 0; m_irq[d] = 0; m_st[d] = 0;
            end else begin
                wrap = 1'b0;
                if (load) begin
                    m_cnt[d] = load_val & m_max[d];
                end else if (m_st[d] == 1 && en && pulse && mode != 2'd3) begin
                    if (m_cnt[d] == m_max[d]) begin
                        wrap = 1'b1;
                        m_cnt[d] = (mode == 2'd0) ? 0 : (reload_val & m_max[d]);
                    end else begin
                        m_cnt[d] = m_cnt[d] + 1;
                    end
                end
                m_irq[d] = wrap;
                if (wrap) m_ovf[d] = 1'b1;
                else if (ovf_clr) m_ovf[d] = 1'b0;
                case (m_st[d])
                    0: if (en) m_st[d] = 1;
                    1: if (!en) m_st[d] = 0; else if (wrap && mode == 2'd2) m_st[d] = 2;
                    default: if (!en) m_st[d] = 0;
                endcase
            end
        end
        if (rst) begin
            for (int i = 0; i <= S; i++) h[i] = 1'b0;
        end else begin
            for (int i = S; i > 0; i--) h[i] = h[i-1];
            h[0] = tick_in;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;
    int ph       = 0;
    bit tick_gen = 1'b0;
    bit tick_rnd = 1'b0;
    int tick_left = 0;
    int ar_exp[6] = '{13, 14, 15, 12, 13, 14};
    bit ar_irq[6] = '{0, 0, 0, 1, 0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clk_in cycle: advance the tick waveform, let the edge happen, compare on the falling edge.
    task automatic step();
        if (tick_gen) begin
            if (tick_left == 0) begin
                tick_in   = ~tick_in;
                tick_left = tick_rnd ? int'($urandom_range(2, 5)) : 4;
            end
            tick_left--;
        end
        @(posedge clk_in);
        @(negedge clk_in);
        ph = (ph + 1) % 8;
        chk("m_cnt4",  cnt4,  m_cnt[0]);
        chk("m_ovf4",  ovf4,  m_ovf[0]);
        chk("m_irq4",  irq4,  m_irq[0]);
        chk("m_run4",  run4,  m_st[0] == 1);
        chk("m_cnt16", cnt16, m_cnt[1]);
        chk("m_ovf16", ovf16, m_ovf[1]);
        chk("m_irq16", irq16, m_irq[1]);
        chk("m_run16", run16, m_st[1] == 1);
    endtask

    // Steps until the tick phase counter reaches p (phase 0 = just after a count update).
    task automatic run_to_ph(input int p);
        for (int i = 0; i < 8; i++) begin
            step();
            if (ph == p) break;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        rst = 1'b1; tick_in = 1'b0; en = 1'b0; mode = 2'd0;
        reload_val = '0; load_val = '0; load = 1'b0; ovf_clr = 1'b0;
        @(negedge clk_in);
        repeat (3) step();
        chk("rst_cnt16", cnt16, 0);
        chk("rst_ovf16", ovf16, 0);
        chk("rst_irq16", irq16, 0);
        chk("rst_run16", run16, 0);

        // free-run, square wave of period 8
        rst = 1'b0; en = 1'b1;
        step(); step();
        chk("run_after_en", run16, 1);
        tick_in = 1'b1; tick_left = 4; tick_gen = 1'b1;
        step(); chk("lat_e1", cnt16, 0);
        step(); chk("lat_e2", cnt16, 0);
        step(); chk("lat_e3", cnt16, 1);
        chk("lat_e3_u4", cnt4, 1);
        ph = 0;
        repeat (64) step();
        chk("period_cnt16", cnt16, 9);

        // 4-bit wrap in free-run
        for (i = 0; i < 200 && irq4 !== 1'b1; i++) step();
        chk("ovf4_seen", irq4, 1);
        chk("ovf4_cnt", cnt4, 0);
        chk("ovf4_flag", ovf4, 1);
        chk("ovf4_u16_cnt", cnt16, 16);
        step();
        chk("irq4_one_cycle", irq4, 0);
        chk("ovf4_sticky", ovf4, 1);
        run_to_ph(3); ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk("ovf4_clr", ovf4, 0);
        load_val = 16'd15; load = 1'b1; step(); load = 1'b0;
        chk("load15_u4", cnt4, 15);
        run_to_ph(7); ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk("clr_vs_ovf_flag", ovf4, 1);
        chk("clr_vs_ovf_irq", irq4, 1);
        chk("clr_vs_ovf_cnt", cnt4, 0);

        // auto-reload to 12
        mode = 2'd1; reload_val = 16'd12;
        run_to_ph(3); load_val = 16'd12; load = 1'b1; step(); load = 1'b0;
        chk("ar_load", cnt4, 12);
        for (int k = 0; k < 6; k++) begin
            run_to_ph(0);
            chk("ar_seq_cnt", cnt4, ar_exp[k]);
            chk("ar_seq_irq", irq4, ar_irq[k]);
        end

        // one-shot with reload 5
        mode = 2'd2; reload_val = 16'd5;
        run_to_ph(3); load_val = 16'd14; load = 1'b1; step(); load = 1'b0;
        run_to_ph(0); chk("os_15", cnt4, 15);
        run_to_ph(0);
        chk("os_reload", cnt4, 5);
        chk("os_irq", irq4, 1);
        chk("os_done_running", run4, 0);
        chk("os_u16_running", run16, 1);
        repeat (16) step();
        chk("os_ignored", cnt4, 5);
        run_to_ph(2); en = 1'b0; step();
        chk("os_idle_run", run4, 0);
        en = 1'b1; step();
        chk("os_rearm_run", run4, 1);
        run_to_ph(0);
        chk("os_restart", cnt4, 6);

        // load coincident with a tick update
        mode = 2'd0;
        run_to_ph(7); load_val = 16'h00AB; load = 1'b1; step(); load = 1'b0;
        chk("ld_tick_cnt16", cnt16, 16'h00AB);
        chk("ld_tick_irq16", irq16, 0);
        chk("ld_tick_cnt4", cnt4, 4'hB);
        run_to_ph(0);
        chk("ld_next_cnt16", cnt16, 16'h00AC);

        // reset mid-count with tick_in held high through reset
        run_to_ph(3); tick_gen = 1'b0; tick_in = 1'b1; rst = 1'b1;
        step();
        chk("midrst_cnt16", cnt16, 0);
        chk("midrst_cnt4", cnt4, 0);
        chk("midrst_ovf4", ovf4, 0);
        chk("midrst_run16", run16, 0);
        step();
        rst = 1'b0;
        step(); chk("rst_hi_e1", cnt16, 0);
        step(); chk("rst_hi_e2", cnt16, 0);
        step(); chk("rst_hi_e3", cnt16, 1);

        // random traffic against the model
        tick_rnd = 1'b1; tick_left = 2; tick_gen = 1'b1;
        repeat (2500) begin
            if ($urandom_range(0, 39) == 0) begin
                load = 1'b1;
                load_val = ($urandom_range(0, 1) == 0) ? 16'($urandom)
                                                       : (16'hFFF0 | 16'($urandom_range(0, 15)));
            end
            if ($urandom_range(0, 19) == 0) ovf_clr = 1'b1;
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 79) == 0) en = ~en;
            if ($urandom_range(0, 49) == 0) reload_val = 16'($urandom);
            if ($urandom_range(0, 399) == 0) rst = 1'b1;
            step();
            load = 1'b0; ovf_clr = 1'b0; rst = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
